fir_decim_hold: RTL and testbench
=================================

Name: fir_decim_hold

Overview:
- Sits directly downstream of the direct-form FIR low-pass on the ADC channel-1 path.
- Decimates the filtered 16-bit stream by a runtime ratio R with a selectable sampling phase, and issues a one-cycle valid strobe per retained sample.
- Also drives a zero-order-hold copy of the decimated stream at full clock rate for the DAC output.
- An optional peak-magnitude tracker on the decimated samples is available for monitoring.

Parameters:
- CNT_W, 8, width of ratio/phase ports and the internal phase counter (R up to 2^CNT_W-1).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-low (0 = reset)
- cke  input  1  sample enable, same meaning as the FIR's cke; 0 freezes all state
- din  input  16  signed FIR output sample
- ratio  input  CNT_W  decimation ratio R; 0 or 1 = no decimation
- phase  input  CNT_W  index within each R-sample frame that is retained
- peak_clr  input  1  clears the peak tracker (ignored unless FIR_PEAK_EN)
- dout_dec  output  16  signed decimated sample
- dec_valid  output  1  one-cycle strobe, dout_dec updated this cycle
- dout_hold  output  16  signed zero-order-hold output for the DAC
- peak_abs  output  16  unsigned peak |sample| since last clear

Behaviour:
- Reset (rst=0 at a clock edge):
  - cnt=0; dout_dec=0, dec_valid=0, dout_hold=0, peak_abs=0.
  - Shadow registers load r_sh and ph_sh from the ratio/phase ports every reset cycle.
  - Reset asserted mid-frame aborts the frame; no strobe is issued for it.
- Effective values:
  - R_eff = (ratio<=1) ? 1 : ratio.
  - ph_eff = (phase >= R_eff) ? R_eff-1 : phase.
  - Both are computed when loading the shadow registers.
- Counter: on each clk with rst=1 and cke=1, cnt = (cnt==r_sh-1) ? 0 : cnt+1.
- Shadow update: on the wrap cycle (cke=1, cnt==r_sh-1), r_sh/ph_sh reload from the ports. Ratio/phase changes therefore take effect only at frame boundaries; no partial frames or double strobes.
- Capture: on a clk with cke=1 and cnt==ph_sh:
  - dout_dec <= din and dout_hold <= din at that edge.
  - dec_valid is high for exactly the following cycle.
  - Latency is 1 clock from din to dout_dec.
- dec_valid is 0 in all other cycles. It is forced 0 on any cycle following an edge where cke=0.
- cke=0: cnt, shadows, dout_dec, dout_hold and peak hold their values.
- R_eff=1: every cke cycle captures. dec_valid mirrors cke delayed by 1.
- Width rules:
  - No arithmetic on the data path; values are passed bit-exact.
  - Magnitude |x| uses two's complement negate, with -32768 saturating to 32767 (0x7FFF).
- Frame counter width CNT_W. Ratio 2^CNT_W-1 is legal; cnt never exceeds r_sh-1.

Optional Feature:
- Macro: FIR_PEAK_EN.
- Defined:
  - On each capture, peak_abs <= max(peak_abs, |din|).
  - peak_clr=1 with no capture: peak_abs <= 0.
  - peak_clr=1 coinciding with a capture: peak_abs <= |din| (clear has priority, new sample retained).
  - peak_clr acts regardless of cke.
  - Update visible 1 cycle after the capture edge, aligned with dec_valid.
- Undefined: peak_abs tied to 0, peak_clr unused, no tracker registers synthesised.

Test Plan:
- Reset: hold rst=0 for 3 cycles with din=0x1234, ratio=4 -> dout_dec=0, dout_hold=0, dec_valid=0, peak_abs=0 throughout.
- Decimate: ratio=4, phase=2, cke=1, din ramps 0,1,2,... from the first cycle after reset release -> dec_valid every 4th cycle; dout_dec = 2,6,10,...; dout_hold steps at each strobe and holds between.
- Pass-through and clamp: ratio=0 -> dec_valid continuous, dout_dec = din delayed 1. ratio=3, phase=7 -> behaves as phase=2 (dout_dec = 2,5,8 on ramp).
- Ratio change mid-frame: ratio changes 4->2 at cnt=1 -> current 4-frame completes with its strobe; strobes then every 2 cycles, with no extra or missing strobe at the boundary.
- cke gating: ratio=2, cke toggles 1,0,1,0,... -> counter advances only on cke=1; strobe every 2nd enabled sample; dec_valid never high after a cke=0 edge; outputs frozen while cke=0.
- Peak (FIR_PEAK_EN):
  - Captured samples 100, -32768, 50 -> peak_abs = 100 then 32767 then 32767.
  - peak_clr coinciding with a capture of -7 -> peak_abs = 7.
  - Without the macro, peak_abs stays 0.

Source files
------------

// File: rtl/fir_decim_hold.sv
// -----------------------------------------------------------------------------
// fir_decim_hold
//
// Decimator with zero-order hold, placed after the channel-1 FIR low-pass.
// It keeps one sample out of every R-sample frame, at a selectable phase
// within the frame, and raises a one-cycle strobe for each kept sample. A
// zero-order-hold copy of the kept stream feeds the DAC at full clock rate.
//
// The ratio and phase ports are copied into shadow registers during reset and
// again at each frame wrap. A change on the ports therefore takes effect at the
// next frame boundary, so a frame is never cut short and never strobes twice.
//
// Optional feature (macro FIR_PEAK_EN): tracks the peak |sample| of the kept
// samples. Without the macro, peak_abs is tied to zero and peak_clr is unused.
//
// Ports:
//   clk        system clock; all logic updates on the rising edge
//   rst        synchronous reset, active low (0 = reset)
//   cke        sample enable; 0 freezes all state
//   din        signed 16-bit FIR output sample
//   ratio      decimation ratio R; 0 or 1 means no decimation
//   phase      index within each frame that is kept (clamped to R-1)
//   peak_clr   clears the peak tracker (FIR_PEAK_EN only)
//   dout_dec   signed decimated sample
//   dec_valid  one-cycle strobe; dout_dec was updated at this edge
//   dout_hold  signed zero-order-hold output for the DAC
//   peak_abs   unsigned peak |sample| since the last clear
// -----------------------------------------------------------------------------
module fir_decim_hold #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cke,
  input  logic [15:0]      din,
  input  logic [CNT_W-1:0] ratio,
  input  logic [CNT_W-1:0] phase,
  input  logic             peak_clr,
  output logic [15:0]      dout_dec,
  output logic             dec_valid,
  output logic [15:0]      dout_hold,
  output logic [15:0]      peak_abs
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] r_sh;
  logic [CNT_W-1:0] ph_sh;
  logic [CNT_W-1:0] r_eff;
  logic [CNT_W-1:0] ph_eff;
  logic             wrap;
  logic             capture;

  // Clamp the port values before they go into the shadow registers. After
  // clamping, r_sh is never 0 and ph_sh is always below r_sh.
  // NOTE: each output of always_comb is assigned on every path, so no latch
  // is inferred.
  always_comb begin
    r_eff  = (ratio <= CNT_W'(1)) ? CNT_W'(1) : ratio;
    ph_eff = (phase >= r_eff) ? (r_eff - CNT_W'(1)) : phase;
  end

  assign wrap    = (cnt == (r_sh - CNT_W'(1)));
  assign capture = cke && (cnt == ph_sh);

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every read in this block sees the value from before the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt       <= '0;
      // NOTE: the shadows reload from the ports during reset rather than
      // clearing to a constant, so the first frame uses the configured ratio.
      r_sh      <= r_eff;
      ph_sh     <= ph_eff;
      dout_dec  <= '0;
      dout_hold <= '0;
      dec_valid <= 1'b0;
    end else begin
      // capture already includes cke, so a cke=0 edge clears the strobe.
      dec_valid <= capture;
      if (cke) begin
        if (wrap) begin
          cnt   <= '0;
          r_sh  <= r_eff;
          ph_sh <= ph_eff;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        if (capture) begin
          dout_dec  <= din;
          dout_hold <= din;
        end
      end
    end
  end

`ifdef FIR_PEAK_EN
  logic [15:0] mag;

  // |din| by two's complement negation; -32768 has no positive counterpart
  // and saturates to 32767.
  always_comb begin
    if (!din[15]) begin
      mag = din;
    end else if (din == 16'h8000) begin
      mag = 16'h7FFF;
    end else begin
      mag = (~din) + 16'd1;
    end
  end

  // peak_clr is acted on even when cke=0. A clear that coincides with a
  // capture keeps the new sample, so that sample is not lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      peak_abs <= '0;
    end else if (peak_clr) begin
      peak_abs <= capture ? mag : 16'd0;
    end else if (capture && (mag > peak_abs)) begin
      peak_abs <= mag;
    end
  end
`else
  logic unused_peak_clr;

  assign unused_peak_clr = peak_clr;
  assign peak_abs        = '0;
`endif

endmodule

// File: tb/tb_fir_decim_hold.sv
// -----------------------------------------------------------------------------
// tb_fir_decim_hold
//
// Self-checking bench for fir_decim_hold. A table of ratio/phase settings with
// hand-computed effective values drives ramp stimulus. Hand-written sequences
// cover reset abort, a ratio change in the middle of a frame, cke gating and
// the peak tracker. Each expected capture is pushed to a queue when it is
// driven, and is popped when the DUT raises dec_valid.
// -----------------------------------------------------------------------------
module tb_fir_decim_hold;

  logic        clk = 1'b0;
  logic        rst;
  logic        cke;
  logic [15:0] din;
  logic [7:0]  ratio;
  logic [7:0]  phase;
  logic        peak_clr;
  logic [15:0] dout_dec;
  logic        dec_valid;
  logic [15:0] dout_hold;
  logic [15:0] peak_abs;

  int checks = 0;
  int errors = 0;

  logic [15:0] sb[$];
  logic [15:0] hold_exp;
  int          exp_peak;

  typedef struct {
    logic [7:0] ratio;
    logic [7:0] phase;
    int         eff_r;
    int         eff_ph;
    int         frames;
  } cfg_t;

  cfg_t cfgs[6];

  fir_decim_hold #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cke       (cke),
    .din       (din),
    .ratio     (ratio),
    .phase     (phase),
    .peak_clr  (peak_clr),
    .dout_dec  (dout_dec),
    .dec_valid (dec_valid),
    .dout_hold (dout_hold),
    .peak_abs  (peak_abs)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mag_of(input logic [15:0] x);
    int v;
    v = int'($signed(x));
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  // Hold reset for n edges with the given ratio/phase on the ports. Every
  // output must read zero after each reset edge. Reset is released at the end.
  task automatic do_reset(input int n, input logic [7:0] r, input logic [7:0] p);
    rst      = 1'b0;
    ratio    = r;
    phase    = p;
    din      = 16'h1234;
    cke      = 1'b1;
    peak_clr = 1'b0;
    sb.delete();
    hold_exp = '0;
    exp_peak = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      check("rst_dout_dec", int'(dout_dec), 0);
      check("rst_dec_valid", int'(dec_valid), 0);
      check("rst_dout_hold", int'(dout_hold), 0);
      check("rst_peak_abs", int'(peak_abs), 0);
    end
    rst = 1'b1;
  endtask

  // Apply one clock edge. cap states whether this edge is expected to
  // retain d.
  task automatic run_cycle(input logic [15:0] d, input logic c,
                           input logic clr, input bit cap);
    logic [15:0] exp_d;
    din      = d;
    cke      = c;
    peak_clr = clr;
    if (cap) sb.push_back(d);
    @(posedge clk);
    #1;
    if (cap) hold_exp = d;
`ifdef FIR_PEAK_EN
    if (clr) exp_peak = cap ? mag_of(d) : 0;
    else if (cap && (mag_of(d) > exp_peak)) exp_peak = mag_of(d);
`endif
    check("dec_valid", int'(dec_valid), int'(cap));
    if (dec_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_strobe: got dout_dec %0d with nothing expected at %0t",
                 dout_dec, $time);
      end else begin
        exp_d = sb.pop_front();
        check("dout_dec_sb", int'(dout_dec), int'(exp_d));
      end
    end
    check("dout_dec_held", int'(dout_dec), int'(hold_exp));
    check("dout_hold", int'(dout_hold), int'(hold_exp));
    check("peak_abs", int'(peak_abs), exp_peak);
  endtask

  initial begin
    cfgs[0] = '{ratio: 8'd4,   phase: 8'd2,   eff_r: 4,   eff_ph: 2,   frames: 4};
    cfgs[1] = '{ratio: 8'd0,   phase: 8'd0,   eff_r: 1,   eff_ph: 0,   frames: 8};
    cfgs[2] = '{ratio: 8'd1,   phase: 8'd5,   eff_r: 1,   eff_ph: 0,   frames: 6};
    cfgs[3] = '{ratio: 8'd3,   phase: 8'd7,   eff_r: 3,   eff_ph: 2,   frames: 3};
    cfgs[4] = '{ratio: 8'd5,   phase: 8'd0,   eff_r: 5,   eff_ph: 0,   frames: 3};
    cfgs[5] = '{ratio: 8'd255, phase: 8'd254, eff_r: 255, eff_ph: 254, frames: 2};

    hold_exp = '0;
    exp_peak = 0;

    // Reset held for 3 edges with din=0x1234 and ratio=4.
    do_reset(3, 8'd4, 8'd2);

    // Table-driven ramps. A sample k is retained when k mod R_eff == ph_eff.
    for (int i = 0; i < 6; i++) begin
      do_reset(2, cfgs[i].ratio, cfgs[i].phase);
      for (int k = 0; k < cfgs[i].eff_r * cfgs[i].frames; k++) begin
        run_cycle(16'(k), 1'b1, 1'b0, (k % cfgs[i].eff_r) == cfgs[i].eff_ph);
      end
      check("sb_drained", sb.size(), 0);
    end

    // Reset asserted on the edge that would have captured (cnt=3). No strobe
    // is issued, and the next frame starts again from cnt=0.
    do_reset(2, 8'd4, 8'd3);
    for (int k = 0; k < 3; k++) run_cycle(16'(k), 1'b1, 1'b0, 1'b0);
    do_reset(1, 8'd4, 8'd3);
    for (int k = 0; k < 8; k++) run_cycle(16'(100 + k), 1'b1, 1'b0, (k % 4) == 3);
    check("abort_sb_drained", sb.size(), 0);

    // Ratio changes 4->2 while cnt=1, with phase=3. The 4-frame finishes with
    // its strobe at edge 3. From then on the 2-frame uses phase clamped to 1,
    // giving captures at edges 3, 5, 7, 9, 11.
    begin
      logic [11:0] cap_mask;
      cap_mask = 12'hAA8;
      do_reset(2, 8'd4, 8'd3);
      run_cycle(16'd0, 1'b1, 1'b0, cap_mask[0]);
      ratio = 8'd2;
      for (int k = 1; k < 12; k++) run_cycle(16'(k), 1'b1, 1'b0, cap_mask[k]);
      check("ratio_chg_sb_drained", sb.size(), 0);
    end

    // cke gating with ratio=2, phase=1, and cke alternating 1,0,1,0,... Only
    // every second enabled sample is retained, and nothing moves while cke=0.
    do_reset(2, 8'd2, 8'd1);
    for (int k = 0; k < 16; k++) begin
      run_cycle(16'(16'h0200 + k), (k % 2) == 0, 1'b0,
                ((k % 2) == 0) && (((k / 2) % 2) == 1));
    end
    check("cke_sb_drained", sb.size(), 0);

    // Peak tracker in pass-through mode. Expected peak values are
    // 100, 32767, 32767, then 0 after a clear with cke=0, then 7 when a clear
    // coincides with the capture of -7.
    do_reset(2, 8'd1, 8'd0);
    run_cycle(16'd100,  1'b1, 1'b0, 1'b1);
    run_cycle(16'h8000, 1'b1, 1'b0, 1'b1);
    run_cycle(16'd50,   1'b1, 1'b0, 1'b1);
    run_cycle(16'd9,    1'b0, 1'b1, 1'b0);
    run_cycle(16'hFFF9, 1'b1, 1'b1, 1'b1);
`ifdef FIR_PEAK_EN
    check("peak_final", int'(peak_abs), 7);
`else
    check("peak_final", int'(peak_abs), 0);
`endif
    check("peak_dout_dec", int'(dout_dec), 16'hFFF9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
